// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared pointer types and Gray helpers for the async FIFO controllers
package async_fifo_pkg;

  localparam int DEFAULT_ADDRESS_BITS = 4;
  localparam int DEFAULT_DEPTH        = 2 ** DEFAULT_ADDRESS_BITS;

  // Pointer carries one extra wrap bit beyond the RAM address
  typedef logic [DEFAULT_ADDRESS_BITS:0] ptr_t;

  // Number of RAM entries for a given address width
  function automatic int depth_of(input int address_bits);
    return 1 << address_bits;
  endfunction

  // Works for any width up to 32 as long as the unused upper bits are zero
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave narrower values intact
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin     = '0;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - async FIFO write-side pointer, full/almost-full, level and overflow
module wptr_full_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDRESS_BITS       = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                    write_clk,
  input  logic                    write_rst,
  input  logic                    write_inc,
  input  logic [ADDRESS_BITS:0]   wq2_read_ptr,
  output logic [ADDRESS_BITS-1:0] write_addr,
  output logic                    write_en_mem,
  output logic [ADDRESS_BITS:0]   write_ptr,
  output logic                    write_full,
  output logic                    write_almost_full,
  output logic [ADDRESS_BITS:0]   write_level,
  output logic                    write_overflow
);

  localparam int PW    = ADDRESS_BITS + 1;
  localparam int DEPTH = depth_of(ADDRESS_BITS);
  localparam logic [ADDRESS_BITS:0] AF_THRESHOLD = PW'(DEPTH - ALMOST_FULL_MARGIN);

  logic [ADDRESS_BITS:0] wbin;
  logic [ADDRESS_BITS:0] wbin_next;
  logic [ADDRESS_BITS:0] wgray_next;
  logic [ADDRESS_BITS:0] rbin;
  logic [ADDRESS_BITS:0] level_next;
  logic [ADDRESS_BITS:0] full_pattern;
  logic                  push;
  logic                  full_next;
  logic                  almost_full_next;

  assign push         = write_inc & ~write_full;
  assign write_en_mem = push;
  assign write_addr   = wbin[ADDRESS_BITS-1:0];

  // Full when the write pointer is one lap ahead: the two MSBs of the Gray read pointer are inverted
  assign full_pattern = {~wq2_read_ptr[ADDRESS_BITS:ADDRESS_BITS-1], wq2_read_ptr[ADDRESS_BITS-2:0]};

  // Next-state pointers and flags; a read-pointer move and a write in the same cycle fold together here
  always_comb begin
    wbin_next        = wbin + PW'(push);
    wgray_next       = PW'(bin2gray(32'(wbin_next)));
    rbin             = PW'(gray2bin(32'(wq2_read_ptr)));
    level_next       = wbin_next - rbin;
    full_next        = (wgray_next == full_pattern);
    almost_full_next = (level_next >= AF_THRESHOLD);
  end

  // All write-side state updates together; write_ptr is a pure flop so the crossing sees one-bit steps
  always_ff @(posedge write_clk or posedge write_rst) begin
    if (write_rst) begin
      wbin              <= '0;
      write_ptr         <= '0;
      write_full        <= 1'b0;
      write_almost_full <= 1'b0;
      write_level       <= '0;
      write_overflow    <= 1'b0;
    end else begin
      wbin              <= wbin_next;
      write_ptr         <= wgray_next;
      write_full        <= full_next;
      write_almost_full <= almost_full_next;
      write_level       <= level_next;
      if (write_inc && write_full) begin
        write_overflow <= 1'b1;
      end
    end
  end

endmodule
